ifu_fetch_ctrl: RTL

Instruction-fetch controller that sits directly upstream of the IF/ID pipeline register and replaces the purely combinational fetch path. It owns the sequential fetch PC, which advances by 4 each fetch or is loaded from a redirect. It issues one request at a time to instruction memory over a valid/ready request channel and accepts the matching response. It buffers fetched {pc, inst, fault} entries in a small FIFO and delivers them to IF/ID over a valid/ready handshake.

---
 rtl/ifu_fetch_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller feeding the IF/ID pipeline register.
// Owns the sequential fetch PC, issues one instruction-memory request at a
// time, and buffers fetched {pc, inst, fault} entries in a small FIFO whose
// head is presented to IF/ID through registered outputs.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   redirect_valid_i/   redirect request and new fetch PC; flushes the block
//   redirect_pc_i
//   imem_req_*          request channel to instruction memory (valid/ready)
//   imem_resp_*         single-cycle response (data, access fault)
//   inst_*              entry delivered to IF/ID (valid/ready)
module ifu_fetch_ctrl #(
  parameter int unsigned            XLEN       = 64,
  parameter int unsigned            INST_LEN   = 32,
  parameter logic [XLEN-1:0]        RESET_PC   = 64'h8000_0000,
  parameter int unsigned            FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                imem_req_valid_o,
  input  logic                imem_req_ready_i,
  output logic [XLEN-1:0]     imem_req_addr_o,
  input  logic                imem_resp_valid_i,
  input  logic [INST_LEN-1:0] imem_resp_data_i,
  input  logic                imem_resp_err_i,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  output logic [XLEN-1:0]     inst_addr_o,
  output logic [INST_LEN-1:0] inst_data_o,
  output logic                inst_fault_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]     pending_pc_q, pending_pc_d;
  logic                halt_push_q, halt_push_d;

  logic [XLEN-1:0]     mem_addr_q  [FIFO_DEPTH];
  logic [INST_LEN-1:0] mem_data_q  [FIFO_DEPTH];
  logic                mem_fault_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       remaining;

  logic [XLEN-1:0]     out_addr_q, out_addr_d;
  logic [INST_LEN-1:0] out_data_q, out_data_d;
  logic                out_fault_q, out_fault_d;

  logic                req_hs;
  logic                pop;
  logic                push;
  logic                flush;
  logic [XLEN-1:0]     push_addr;
  logic [INST_LEN-1:0] push_data;
  logic                push_fault;

  // Request is suppressed while reset is held so no request leaks out
  // during reset even though the state register already reads REQ.
  assign imem_req_valid_o = rst && (state_q == S_REQ) && (count_q < CW'(FIFO_DEPTH));
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;

  assign inst_valid_o = (count_q != '0) && !redirect_valid_i;
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_addr_o  = out_addr_q;
  assign inst_data_o  = out_data_q;
  assign inst_fault_o = out_fault_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    halt_push_d  = halt_push_q;
    push         = 1'b0;
    push_addr    = pending_pc_q;
    push_data    = '0;
    push_fault   = 1'b0;
    flush        = 1'b0;

    case (state_q)
      S_REQ: begin
        if (req_hs) begin
          pending_pc_d = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + XLEN'(4);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid_i) begin
          push       = 1'b1;
          push_addr  = pending_pc_q;
          push_data  = imem_resp_err_i ? '0 : imem_resp_data_i;
          push_fault = imem_resp_err_i;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_resp_valid_i) state_d = S_REQ;
      end
      S_HALT: begin
        // fetch_pc_q already holds the misaligned redirect target.
        if (halt_push_q) begin
          push        = 1'b1;
          push_addr   = fetch_pc_q;
          push_data   = '0;
          push_fault  = 1'b1;
          halt_push_d = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid_i) begin
      flush       = 1'b1;
      push        = 1'b0;
      fetch_pc_d  = redirect_pc_i;
      halt_push_d = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_d     = S_HALT;
        halt_push_d = 1'b1;
      end else begin
        case (state_q)
          S_REQ:   state_d = req_hs ? S_DROP : S_REQ;
          S_WAIT:  state_d = imem_resp_valid_i ? S_REQ : S_DROP;
          S_DROP:  state_d = imem_resp_valid_i ? S_REQ : S_DROP;
          default: state_d = S_REQ;
        endcase
      end
    end
  end

  // FIFO bookkeeping; the registered head is refreshed with whatever entry
  // will be at the head after this cycle's pop/push, else held.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_fault_d = out_fault_q;
    remaining   = count_q - CW'(pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = remaining + CW'(push);
      if (count_d != '0) begin
        if (remaining == '0) begin
          out_addr_d  = push_addr;
          out_data_d  = push_data;
          out_fault_d = push_fault;
        end else begin
          out_addr_d  = mem_addr_q[rd_ptr_d];
          out_data_d  = mem_data_q[rd_ptr_d];
          out_fault_d = mem_fault_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      halt_push_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      halt_push_q  <= halt_push_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_fault_q  <= out_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q]  <= push_addr;
      mem_data_q[wr_ptr_q]  <= push_data;
      mem_fault_q[wr_ptr_q] <= push_fault;
    end
  end

endmodule
